// File: rtl/key_event_fsm_pkg.sv
// Shared definitions for the key event classifier: state encodings, default tick counts
// and a width helper.
package key_event_fsm_pkg;

  localparam int KEY_LONG_TICKS = 100;
  localparam int KEY_REP_TICKS  = 20;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_LONG  = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_fsm_if.sv
// Key level in, classified single-cycle events out. The slave modport is the classifier
// side, and the master modport is the consumer/driver side.
interface key_event_fsm_if;
  logic key_in;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic key_held;

  modport slave  (input key_in, output short_pulse, long_pulse, repeat_pulse, key_held);
  modport master (output key_in, input short_pulse, long_pulse, repeat_pulse, key_held);
endinterface

// File: rtl/key_edge_det.sv
// Previous-sample register and press-edge detect for the debounced key level.
module key_edge_det #(
  parameter bit PRESS_LVL = 1'b1
) (
  input  logic clk100hz,
  input  logic rst_n,
  input  logic i_key,
  output logic o_pressed,
  output logic o_press_edge
);

  logic r_key_q;
  logic w_pressed;

  assign w_pressed = (i_key == PRESS_LVL);

  // Resetting to "pressed" means a key held through reset never produces an edge.
  always_ff @(posedge clk100hz or negedge rst_n) begin
    if (!rst_n) r_key_q <= 1'b1;
    else        r_key_q <= w_pressed;
  end

  assign o_pressed    = w_pressed;
  assign o_press_edge = w_pressed & ~r_key_q;

endmodule

// File: rtl/key_event_fsm.sv
// Short/long/auto-repeat key event classifier; KEY_REPEAT_EN enables the repeat pulses.
// state    | meaning
// ST_IDLE  | waiting for a press edge
// ST_PRESS | counting pressed samples towards a long press
// ST_LONG  | long press reported, waiting for release (repeats if enabled)
module key_event_fsm
  import key_event_fsm_pkg::*;
#(
  parameter int LONG_TICKS = KEY_LONG_TICKS,
  parameter int REP_TICKS  = KEY_REP_TICKS,
  parameter bit PRESS_LVL  = 1'b1
) (
  input  logic         clk100hz,
  input  logic         rst_n,
  key_event_fsm_if.slave kev
);

  localparam int CW = $clog2(max_int(LONG_TICKS, REP_TICKS) + 1);
  localparam logic [CW-1:0] LONG_C = CW'(LONG_TICKS);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_C  = CW'(REP_TICKS);
`endif

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_short;
  logic          r_long;
  logic          r_held;
  logic          w_p;
  logic          w_edge;

  key_edge_det #(.PRESS_LVL(PRESS_LVL)) u_edge (
    .clk100hz     (clk100hz),
    .rst_n        (rst_n),
    .i_key        (kev.key_in),
    .o_pressed    (w_p),
    .o_press_edge (w_edge)
  );

  assign w_cnt_inc = r_cnt + 1'b1;

`ifdef KEY_REPEAT_EN
  logic r_rep;
`endif

  always_ff @(posedge clk100hz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rep   <= 1'b0;
`endif
    end else begin
      r_short <= 1'b0;
      r_long  <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rep   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            r_state <= ST_PRESS;
            r_cnt   <= CW'(1);
            r_held  <= 1'b1;
          end
        end
        ST_PRESS: begin
          if (w_p) begin
            if (w_cnt_inc == LONG_C) begin
              r_long  <= 1'b1;
              r_state <= ST_LONG;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            r_short <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
          end
        end
        ST_LONG: begin
          if (!w_p) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
          end
`ifdef KEY_REPEAT_EN
          else if (w_cnt_inc == REP_C) begin
            r_rep <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign kev.short_pulse = r_short;
  assign kev.long_pulse  = r_long;
  assign kev.key_held    = r_held;
`ifdef KEY_REPEAT_EN
  assign kev.repeat_pulse = r_rep;
`else
  assign kev.repeat_pulse = 1'b0;
`endif

endmodule
